// File: rtl/tb_apb_pkg.sv
// Shared types and constants for the testbench-side APB initiator.
// Imported by the master top and its ACCESS-phase wait timer.
package tb_apb_pkg;

  localparam int APB_AW = 32;
  localparam int APB_DW = 32;

  localparam logic [APB_DW-1:0] UPD_WDATA = 32'h0000_0001;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_state_e;

endpackage

// File: rtl/tb_apb_wait_timer.sv
// Counts ACCESS-phase wait cycles and flags the last cycle allowed before abort.
// A TIMEOUT_CYC of 0 never expires, so the master waits indefinitely.
module tb_apb_wait_timer #(
  parameter int TIMEOUT_CYC = 256,
  parameter int CNT_W       = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_expire
);

  localparam logic [CNT_W-1:0] LAST_CNT =
    (TIMEOUT_CYC == 0) ? '0 : CNT_W'(TIMEOUT_CYC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating, so a disabled timeout cannot wrap around.
  always_comb begin
    cnt_d = cnt_q;
    if (i_clr) begin
      cnt_d = '0;
    end else if (i_en && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign o_expire = (TIMEOUT_CYC != 0) && (cnt_q == LAST_CNT);

endmodule

// File: rtl/tb_apb_master.sv
// Testbench-side APB requester: turns valid/ready commands and update triggers
// into SETUP/ACCESS cycles, with all outputs registered.
module tb_apb_master
  import tb_apb_pkg::*;
#(
  parameter logic [APB_AW-1:0] UPDATE_ADDR = 32'h0000_0000,
  parameter int                TIMEOUT_CYC = 256,
  parameter int                CNT_W       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_cmd_valid,
  output logic              o_cmd_ready,
  input  logic              i_cmd_write,
  input  logic [APB_AW-1:0] i_cmd_addr,
  input  logic [APB_DW-1:0] i_cmd_wdata,
  input  logic              i_upd_req,
  output logic              o_rsp_valid,
  output logic [APB_DW-1:0] o_rsp_rdata,
  output logic              o_rsp_timeout,
  output logic              o_upd_done,
  output logic              o_busy,
  output logic              o_psel,
  output logic              o_penable,
  output logic              o_pwrite,
  output logic [APB_AW-1:0] o_paddr,
  output logic [APB_DW-1:0] o_pwdata,
  input  logic [APB_DW-1:0] i_prdata,
  input  logic              i_pready
);

  apb_state_e        state_q, state_d;
  logic              upd_pending_q, upd_pending_d;
  logic              is_upd_q, is_upd_d;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [APB_AW-1:0] paddr_q, paddr_d;
  logic [APB_DW-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [APB_DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_timeout_q, rsp_timeout_d;
  logic              upd_done_q, upd_done_d;

  logic cmd_ready;
  logic timer_clr;
  logic timer_en;
  logic timer_expire;
  logic xfer_end;
  logic xfer_abort;

  assign cmd_ready = (state_q == IDLE) && !upd_pending_q && !rst;

  tb_apb_wait_timer #(
    .TIMEOUT_CYC (TIMEOUT_CYC),
    .CNT_W       (CNT_W)
  ) u_wait_timer (
    .clk      (clk),
    .rst      (rst),
    .i_clr    (timer_clr),
    .i_en     (timer_en),
    .o_expire (timer_expire)
  );

  // pready wins over expiry, so a slave answering on the last allowed cycle completes normally.
  assign xfer_end   = (state_q == ACCESS) && i_pready;
  assign xfer_abort = (state_q == ACCESS) && !i_pready && timer_expire;

  always_comb begin
    state_d       = state_q;
    upd_pending_d = upd_pending_q | i_upd_req;
    is_upd_d      = is_upd_q;
    psel_d        = psel_q;
    penable_d     = penable_q;
    pwrite_d      = pwrite_q;
    paddr_d       = paddr_q;
    pwdata_d      = pwdata_q;
    rsp_valid_d   = 1'b0;
    rsp_rdata_d   = '0;
    rsp_timeout_d = 1'b0;
    upd_done_d    = 1'b0;
    timer_clr     = 1'b0;
    timer_en      = 1'b0;

    case (state_q)
      IDLE: begin
        if (upd_pending_q) begin
          state_d       = SETUP;
          upd_pending_d = i_upd_req;
          is_upd_d      = 1'b1;
          psel_d        = 1'b1;
          pwrite_d      = 1'b1;
          paddr_d       = UPDATE_ADDR;
          pwdata_d      = UPD_WDATA;
        end else if (i_cmd_valid && cmd_ready) begin
          state_d  = SETUP;
          is_upd_d = 1'b0;
          psel_d   = 1'b1;
          pwrite_d = i_cmd_write;
          paddr_d  = i_cmd_addr;
          pwdata_d = i_cmd_wdata;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        timer_clr = 1'b1;
      end
      ACCESS: begin
        if (xfer_end || xfer_abort) begin
          state_d   = IDLE;
          psel_d    = 1'b0;
          penable_d = 1'b0;
          if (is_upd_q) begin
            upd_done_d = 1'b1;
          end else begin
            rsp_valid_d   = 1'b1;
            rsp_timeout_d = xfer_abort;
            rsp_rdata_d   = (xfer_end && !pwrite_q) ? i_prdata : '0;
          end
        end else begin
          timer_en = 1'b1;
        end
      end
      default: begin
        state_d   = IDLE;
        psel_d    = 1'b0;
        penable_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      upd_pending_q <= 1'b0;
      is_upd_q      <= 1'b0;
      psel_q        <= 1'b0;
      penable_q     <= 1'b0;
      pwrite_q      <= 1'b0;
      paddr_q       <= '0;
      pwdata_q      <= '0;
      rsp_valid_q   <= 1'b0;
      rsp_rdata_q   <= '0;
      rsp_timeout_q <= 1'b0;
      upd_done_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      upd_pending_q <= upd_pending_d;
      is_upd_q      <= is_upd_d;
      psel_q        <= psel_d;
      penable_q     <= penable_d;
      pwrite_q      <= pwrite_d;
      paddr_q       <= paddr_d;
      pwdata_q      <= pwdata_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_rdata_q   <= rsp_rdata_d;
      rsp_timeout_q <= rsp_timeout_d;
      upd_done_q    <= upd_done_d;
    end
  end

  assign o_cmd_ready   = cmd_ready;
  assign o_busy        = (state_q != IDLE) || upd_pending_q;
  assign o_psel        = psel_q;
  assign o_penable     = penable_q;
  assign o_pwrite      = pwrite_q;
  assign o_paddr       = paddr_q;
  assign o_pwdata      = pwdata_q;
  assign o_rsp_valid   = rsp_valid_q;
  assign o_rsp_rdata   = rsp_rdata_q;
  assign o_rsp_timeout = rsp_timeout_q;
  assign o_upd_done    = upd_done_q;

endmodule

// File: tb/tb_tb_apb_master.sv
// Directed bench for tb_apb_master: a vector table of single transfers plus
// hand-written sequences for update priority, coalescing and mid-transfer reset.
module tb_tb_apb_master;

  localparam logic [31:0] UPD_ADDR = 32'h0000_0100;
  localparam int          TMO      = 4;

  logic        clk;
  logic        rst;
  logic        i_cmd_valid;
  logic        o_cmd_ready;
  logic        i_cmd_write;
  logic [31:0] i_cmd_addr;
  logic [31:0] i_cmd_wdata;
  logic        i_upd_req;
  logic        o_rsp_valid;
  logic [31:0] o_rsp_rdata;
  logic        o_rsp_timeout;
  logic        o_upd_done;
  logic        o_busy;
  logic        o_psel;
  logic        o_penable;
  logic        o_pwrite;
  logic [31:0] o_paddr;
  logic [31:0] o_pwdata;
  logic [31:0] i_prdata;
  logic        i_pready;

  int tests_run = 0;
  int tests_failed = 0;
  int upd_done_cnt = 0;
  int upd_setup_cnt = 0;

  typedef struct {
    logic        write;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          waits;
    logic [31:0] prdata;
    logic [31:0] exp_rdata;
    logic        exp_timeout;
    int          exp_acc;
  } vec_t;

  vec_t vecs[6];

  tb_apb_master #(
    .UPDATE_ADDR (UPD_ADDR),
    .TIMEOUT_CYC (TMO),
    .CNT_W       (16)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .i_cmd_valid   (i_cmd_valid),
    .o_cmd_ready   (o_cmd_ready),
    .i_cmd_write   (i_cmd_write),
    .i_cmd_addr    (i_cmd_addr),
    .i_cmd_wdata   (i_cmd_wdata),
    .i_upd_req     (i_upd_req),
    .o_rsp_valid   (o_rsp_valid),
    .o_rsp_rdata   (o_rsp_rdata),
    .o_rsp_timeout (o_rsp_timeout),
    .o_upd_done    (o_upd_done),
    .o_busy        (o_busy),
    .o_psel        (o_psel),
    .o_penable     (o_penable),
    .o_pwrite      (o_pwrite),
    .o_paddr       (o_paddr),
    .o_pwdata      (o_pwdata),
    .i_prdata      (i_prdata),
    .i_pready      (i_pready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Independent event counters for update traffic, sampled mid-cycle.
  always @(negedge clk) begin
    if (o_upd_done) upd_done_cnt++;
    if (o_psel && !o_penable && (o_paddr == UPD_ADDR) && !rst) upd_setup_cnt++;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Drives one command from the current negedge and plays the slave side.
  task automatic apply_stimulus(input vec_t v);
    int acc;
    i_cmd_valid = 1'b1;
    i_cmd_write = v.write;
    i_cmd_addr  = v.addr;
    i_cmd_wdata = v.wdata;
    #1;
    check_output("cmd_ready", 32'(o_cmd_ready), 32'd1);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    i_cmd_addr  = 32'hFFFF_FFF0;
    i_cmd_wdata = 32'hBAD0_BAD0;
    i_pready    = 1'b1;
    i_prdata    = 32'h5E75_5E75;
    check_output("setup_psel", 32'(o_psel), 32'd1);
    check_output("setup_penable", 32'(o_penable), 32'd0);
    check_output("setup_paddr", o_paddr, v.addr);
    check_output("setup_pwrite", 32'(o_pwrite), 32'(v.write));
    check_output("rsp_pulse_width", 32'(o_rsp_valid), 32'd0);
    if (v.write) check_output("setup_pwdata", o_pwdata, v.wdata);
    acc = 0;
    @(negedge clk);
    while (o_penable === 1'b1 && acc < 20) begin
      check_output("access_psel", 32'(o_psel), 32'd1);
      check_output("access_paddr_hold", o_paddr, v.addr);
      i_pready = (acc >= v.waits);
      i_prdata = i_pready ? v.prdata : ~v.prdata;
      acc++;
      @(negedge clk);
    end
    i_pready = 1'b0;
    i_prdata = 32'h0;
    check_output("access_cycles", 32'(acc), 32'(v.exp_acc));
    check_output("end_psel", 32'(o_psel), 32'd0);
    check_output("rsp_valid", 32'(o_rsp_valid), 32'd1);
    check_output("rsp_timeout", 32'(o_rsp_timeout), 32'(v.exp_timeout));
    check_output("rsp_rdata", o_rsp_rdata, v.exp_rdata);
    check_output("cmd_upd_done", 32'(o_upd_done), 32'd0);
  endtask

  initial begin
    int base_done;
    int base_setup;
    vec_t v;

    vecs[0] = '{1'b1, 32'h10, 32'hA5A5_0001, 0,  32'h1234_5678, 32'h0,         1'b0, 1};
    vecs[1] = '{1'b0, 32'h20, 32'h0,         3,  32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 4};
    vecs[2] = '{1'b0, 32'h24, 32'h0,         0,  32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 1};
    vecs[3] = '{1'b1, 32'h28, 32'h7777_0003, 2,  32'hFFFF_FFFF, 32'h0,         1'b0, 3};
    vecs[4] = '{1'b0, 32'h2C, 32'h0,         99, 32'h1111_2222, 32'h0,         1'b1, 4};
    vecs[5] = '{1'b0, 32'h40, 32'h0,         1,  32'h0000_0001, 32'h0000_0001, 1'b0, 2};

    rst = 1'b1;
    i_cmd_valid = 1'b0;
    i_cmd_write = 1'b0;
    i_cmd_addr = 32'h0;
    i_cmd_wdata = 32'h0;
    i_upd_req = 1'b0;
    i_prdata = 32'h0;
    i_pready = 1'b0;

    repeat (3) @(negedge clk);
    check_output("rst_psel", 32'(o_psel), 32'd0);
    check_output("rst_penable", 32'(o_penable), 32'd0);
    check_output("rst_paddr", o_paddr, 32'd0);
    check_output("rst_rsp_valid", 32'(o_rsp_valid), 32'd0);
    check_output("rst_busy", 32'(o_busy), 32'd0);
    check_output("rst_cmd_ready", 32'(o_cmd_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Back-to-back: each call presents its command in the previous response cycle.
    for (int i = 0; i < 6; i++) begin
      apply_stimulus(vecs[i]);
    end
    @(negedge clk);
    check_output("rsp_one_cycle", 32'(o_rsp_valid), 32'd0);

    // Pending update outranks a command already waiting in IDLE.
    base_done = upd_done_cnt;
    i_upd_req = 1'b1;
    @(negedge clk);
    i_upd_req = 1'b0;
    check_output("upd_pending_ready", 32'(o_cmd_ready), 32'd0);
    check_output("upd_pending_busy", 32'(o_busy), 32'd1);
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b1;
    i_cmd_addr  = 32'h30;
    i_cmd_wdata = 32'h3333_3333;
    @(negedge clk);
    check_output("upd_setup_paddr", o_paddr, UPD_ADDR);
    check_output("upd_setup_pwdata", o_pwdata, 32'h1);
    check_output("upd_setup_pwrite", 32'(o_pwrite), 32'd1);
    check_output("upd_setup_psel", 32'(o_psel), 32'd1);
    i_pready = 1'b1;
    @(negedge clk);
    check_output("upd_access_penable", 32'(o_penable), 32'd1);
    @(negedge clk);
    check_output("upd_done", 32'(o_upd_done), 32'd1);
    check_output("upd_no_rsp", 32'(o_rsp_valid), 32'd0);
    check_output("upd_end_psel", 32'(o_psel), 32'd0);
    @(negedge clk);
    i_cmd_valid = 1'b0;
    check_output("cmd_after_upd_paddr", o_paddr, 32'h30);
    check_output("cmd_after_upd_pwdata", o_pwdata, 32'h3333_3333);
    @(negedge clk);
    @(negedge clk);
    i_pready = 1'b0;
    check_output("cmd_after_upd_rsp", 32'(o_rsp_valid), 32'd1);
    check_output("upd_done_once", 32'(upd_done_cnt - base_done), 32'd1);
    @(negedge clk);

    // Three requests during a busy read coalesce into one update write.
    base_done  = upd_done_cnt;
    base_setup = upd_setup_cnt;
    v = '{1'b0, 32'h50, 32'h0, 3, 32'h5050_A0A0, 32'h5050_A0A0, 1'b0, 4};
    fork
      apply_stimulus(v);
      begin
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          i_upd_req = 1'b1;
          @(negedge clk);
          i_upd_req = 1'b0;
        end
      end
    join
    i_pready = 1'b1;
    repeat (6) @(negedge clk);
    i_pready = 1'b0;
    check_output("coalesce_done_cnt", 32'(upd_done_cnt - base_done), 32'd1);
    check_output("coalesce_setup_cnt", 32'(upd_setup_cnt - base_setup), 32'd1);
    check_output("coalesce_idle_busy", 32'(o_busy), 32'd0);

    // Reset in the second ACCESS cycle discards the read and a same-cycle update request.
    i_cmd_valid = 1'b1;
    i_cmd_write = 1'b0;
    i_cmd_addr  = 32'h60;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    @(negedge clk);
    check_output("rstmid_access1", 32'(o_penable), 32'd1);
    @(negedge clk);
    check_output("rstmid_access2", 32'(o_penable), 32'd1);
    rst = 1'b1;
    i_upd_req = 1'b1;
    #1;
    check_output("rstmid_ready_in_rst", 32'(o_cmd_ready), 32'd0);
    @(negedge clk);
    check_output("rstmid_psel", 32'(o_psel), 32'd0);
    check_output("rstmid_penable", 32'(o_penable), 32'd0);
    check_output("rstmid_no_rsp", 32'(o_rsp_valid), 32'd0);
    rst = 1'b0;
    i_upd_req = 1'b0;
    #1;
    check_output("rstmid_ready_after", 32'(o_cmd_ready), 32'd1);
    @(negedge clk);
    check_output("rstmid_no_upd", 32'(o_psel), 32'd0);
    check_output("rstmid_busy", 32'(o_busy), 32'd0);
    check_output("rstmid_no_rsp2", 32'(o_rsp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/tb_apb_master.md
Name: tb_apb_master

Overview:
- Testbench-side APB initiator: the requester end of the APB register bus used by the unit-test register models.
- Converts a simple valid/ready command stream (read or write, 32-bit address/data) into APB SETUP/ACCESS cycles and returns read data plus completion status.
- Owns a built-in "register update" trigger: on request it issues a write of 32'h0000_0001 to UPDATE_ADDR so a register-update pulse fires in the slave model.
- Sits in the UT environment between sequence drivers and any APB register model.

Parameters:
- UPDATE_ADDR, 32'h0000_0000: address written by the update trigger.
- TIMEOUT_CYC, 256: maximum ACCESS-phase cycles before abort; 0 disables the timeout.
- CNT_W, 16: width of the ACCESS wait counter; must satisfy TIMEOUT_CYC < 2^CNT_W.

Ports:
- clk, input, 1: bus clock; all logic on the rising edge.
- rst, input, 1: synchronous, active-high reset.
- i_cmd_valid, input, 1: command request.
- o_cmd_ready, output, 1: command accept.
- i_cmd_write, input, 1: 1 = write, 0 = read.
- i_cmd_addr, input, 32: transfer address.
- i_cmd_wdata, input, 32: write data; ignored for reads.
- i_upd_req, input, 1: single-cycle pulse requesting an update write.
- o_rsp_valid, output, 1: one-cycle pulse when a command transfer ends.
- o_rsp_rdata, output, 32: read data, valid with o_rsp_valid.
- o_rsp_timeout, output, 1: set with o_rsp_valid if the transfer was aborted.
- o_upd_done, output, 1: one-cycle pulse when an update write ends.
- o_busy, output, 1: state != IDLE or an update is pending.
- o_psel, output, 1: APB select.
- o_penable, output, 1: APB enable.
- o_pwrite, output, 1: APB direction.
- o_paddr, output, 32: APB address.
- o_pwdata, output, 32: APB write data.
- i_prdata, input, 32: APB read data.
- i_pready, input, 1: APB ready.

Behaviour:
- Reset values: all outputs 0; state IDLE; upd_pending 0; wait counter 0.
- Everything registered; no combinational path from APB inputs to outputs.
- FSM states:
  - IDLE -> SETUP when upd_pending, or when i_cmd_valid & o_cmd_ready.
  - SETUP -> ACCESS unconditionally after 1 cycle.
  - ACCESS -> IDLE on i_pready, or on timeout.
- Capture: o_cmd_ready = (state==IDLE) & !upd_pending & !rst. On handshake, latch addr/wdata/write into o_paddr/o_pwdata/o_pwrite.
- Update arbitration: an update transfer drives o_paddr = UPDATE_ADDR, o_pwdata = 1, o_pwrite = 1. A pending update has priority over a new command in IDLE.
- upd_pending handling:
  - Set by i_upd_req.
  - Cleared when the update transfer enters SETUP.
  - An i_upd_req arriving while pending stays one request; requests are coalesced and never counted.
  - An i_upd_req in the same cycle as clear re-sets pending.
- Bus signals per phase:
  - SETUP: o_psel = 1, o_penable = 0.
  - ACCESS: o_psel = 1, o_penable = 1; o_paddr, o_pwdata and o_pwrite are held stable.
- Completion: i_pready sampled high in ACCESS ends the transfer. On the next cycle:
  - o_psel = 0 and o_penable = 0.
  - For a command: o_rsp_valid = 1 and o_rsp_rdata = i_prdata as sampled; rdata = 0 for writes.
  - For an update: o_upd_done = 1 and no rsp.
- Minimum transfer: 2 cycles (SETUP + ACCESS with pready). Back-to-back commands have one IDLE cycle between transfers, giving a command period of 3 cycles.
- Timeout:
  - The counter clears on entering ACCESS and increments each ACCESS cycle without pready.
  - When the count reaches TIMEOUT_CYC - 1 with pready still low, abort: o_psel/o_penable drop next cycle and the response is issued with o_rsp_timeout = 1, rdata = 0.
  - An aborted update gives o_upd_done = 1 only.
  - TIMEOUT_CYC = 0 means wait forever.
- Boundaries:
  - i_pready high during SETUP is ignored.
  - A reset mid-transfer drops o_psel/o_penable next cycle, discards the in-flight transfer with no response, and clears upd_pending.

Decomposition:
- Shared package tb_apb_pkg:
  - State enum IDLE/SETUP/ACCESS.
  - APB_AW = 32, APB_DW = 32.
  - UPD_WDATA = 32'h1.
- One sub-module tb_apb_wait_timer (CNT_W counter with clear/enable/expire, TIMEOUT_CYC compare, disable when 0).

Test Plan:
- Write, zero-wait: cmd write addr 0x10 data 0xA5A5_0001, slave pready=1 -> psel high 2 cycles, penable in cycle 2 only, rsp_valid 1 cycle later with timeout=0, rdata=0.
- Read, 3 wait states: read 0x20, pready low 3 ACCESS cycles then high with prdata=0xDEAD_BEEF -> ACCESS lasts 4 cycles, addr stable throughout, rsp_rdata=0xDEAD_BEEF.
- Update priority: i_upd_req and cmd_valid (write 0x30) in same IDLE cycle, UPDATE_ADDR=0x100 -> first transfer is write 0x100 data 0x1 with upd_done pulse, then the 0x30 write with rsp_valid; slave o_reg_update pulses once.
- Timeout: TIMEOUT_CYC=4, pready held 0 -> exactly 4 ACCESS cycles, psel drops, rsp_valid with timeout=1, rdata=0, then ready again.
- Coalesce: 3 upd_req pulses during a busy read -> exactly one update write afterward.
- Reset mid-ACCESS: rst at ACCESS cycle 2 -> psel/penable 0 next cycle, no rsp_valid, o_cmd_ready=1 the cycle after rst releases.
